// File: rtl/imem_loader.sv
// Boot loader that streams a length-prefixed program image into instruction memory.
// The core is held in reset until the full image has been written.
module imem_loader #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int          TIMER_W   = $clog2(TIMEOUT + 1);
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t              state_q;
    logic [15:0]         count_q;
    logic [ADDR_W:0]     word_idx_q;
    logic [1:0]          byte_idx_q;
    logic [TIMER_W-1:0]  timer_q;

    logic                s_ready_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_waddr_q;
    logic [31:0]         imem_wdata_q;
    logic                core_hold_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;

    logic [15:0]         count_d;
    logic [ADDR_W:0]     word_idx_d;
    logic [TIMER_W-1:0]  timer_d;
    logic [23:0]         shift_w;
    logic                accept;
    logic                timer_expired;
    logic                can_start;

    assign accept        = s_valid && s_ready_q;
    assign count_d       = {s_data, count_q[7:0]};
    assign word_idx_d    = word_idx_q + (ADDR_W + 1)'(1);
    assign timer_d       = timer_q + TIMER_W'(1);
    assign timer_expired = (timer_q == TIMER_W'(TIMEOUT - 1));
    assign can_start     = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);

    // Lower three bytes of the word under assembly; the top byte is taken straight
    // from the stream when the word completes.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    lane_q <= '0;
                end else if (state_q == DATA && accept && byte_idx_q == 2'(gi)) begin
                    lane_q <= s_data;
                end
            end
            assign shift_w[8*gi +: 8] = lane_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            timer_q      <= '0;
            s_ready_q    <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= '0;
            core_hold_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            if (start && can_start) begin
                state_q     <= HDR0;
                count_q     <= '0;
                word_idx_q  <= '0;
                byte_idx_q  <= '0;
                timer_q     <= '0;
                s_ready_q   <= 1'b1;
                core_hold_q <= 1'b1;
                busy_q      <= 1'b1;
                done_q      <= 1'b0;
                error_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    HDR0, HDR1, DATA: begin
                        if (accept) begin
                            timer_q <= '0;
                            if (state_q == HDR0) begin
                                count_q[7:0] <= s_data;
                                state_q      <= HDR1;
                            end else if (state_q == HDR1) begin
                                count_q[15:8] <= s_data;
                                if (count_d == 16'd0) begin
                                    state_q     <= DONE;
                                    s_ready_q   <= 1'b0;
                                    busy_q      <= 1'b0;
                                    done_q      <= 1'b1;
                                    core_hold_q <= 1'b0;
                                end else if ({1'b0, count_d} > MAX_WORDS) begin
                                    state_q   <= ERR;
                                    s_ready_q <= 1'b0;
                                    busy_q    <= 1'b0;
                                    error_q   <= 1'b1;
                                end else begin
                                    state_q <= DATA;
                                end
                            end else begin
                                byte_idx_q <= byte_idx_q + 2'd1;
                                if (byte_idx_q == 2'd3) begin
                                    state_q      <= WRITE;
                                    s_ready_q    <= 1'b0;
                                    imem_we_q    <= 1'b1;
                                    imem_waddr_q <= word_idx_q[ADDR_W-1:0];
                                    imem_wdata_q <= {s_data, shift_w};
                                end
                            end
                        end else if (timer_expired) begin
                            // Stalled stream: abandon the session, any partial word is lost.
                            state_q   <= ERR;
                            s_ready_q <= 1'b0;
                            busy_q    <= 1'b0;
                            error_q   <= 1'b1;
                        end else begin
                            timer_q <= timer_d;
                        end
                    end
                    WRITE: begin
                        word_idx_q <= word_idx_d;
                        byte_idx_q <= '0;
                        if (17'(word_idx_d) == {1'b0, count_q}) begin
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            core_hold_q <= 1'b0;
                        end else begin
                            state_q   <= DATA;
                            s_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign s_ready    = s_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_hold  = core_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
